// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin burst-locking mux arbiter.
// Holds the arbiter state encoding and the requester-index width function.
package rr_mux_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Purely combinational rotate-and-priority search: the first requester set
// in req, scanning upward from ptr+1 and wrapping N-1 -> 0.
module rr_grant
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  // Scan from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant       = IW'((int'(ptr) + k) % N);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-to-1 round-robin mux with a one-word registered output stage.
// A word with last=0 locks the grant to its source until that source's last beat.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N-1:0]          req_last,
  input  logic [WIDTH-1:0]      req_data [0:N-1],
  output logic [N-1:0]          req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [$clog2(N)-1:0]  out_src,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int IW = idx_width(N);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    w_ptr_next;
  logic [IW-1:0]    r_lock_id;
  logic [IW-1:0]    w_lock_id_next;

  logic             r_out_valid;
  logic             w_out_valid_next;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_out_data_next;
  logic [IW-1:0]    r_out_src;
  logic [IW-1:0]    w_out_src_next;
  logic             r_out_last;
  logic             w_out_last_next;

  logic [IW-1:0]    w_rr_grant;
  logic             w_rr_valid;
  logic [IW-1:0]    w_grant;
  logic             w_grant_valid;
  logic             w_slot_free;
  logic             w_accept;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;

  rr_grant #(
    .N  (N),
    .IW (IW)
  ) u_rr_grant (
    .req         (req_valid),
    .ptr         (r_ptr),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );

  // While locked, only the burst owner may be granted, valid or not.
  always_comb begin
    w_grant       = w_rr_grant;
    w_grant_valid = w_rr_valid;
    if (r_state == LOCK) begin
      w_grant       = r_lock_id;
      w_grant_valid = req_valid[r_lock_id];
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = w_slot_free && w_grant_valid && !rst;
  assign w_sel_last  = req_last[w_grant];
  assign w_sel_data  = req_data[w_grant];

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign req_ready[gi] = w_accept && (w_grant == IW'(gi));
  end

  // Output stage: load on accept, otherwise drain when downstream takes the word.
  always_comb begin
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    w_out_src_next   = r_out_src;
    w_out_last_next  = r_out_last;
    if (w_accept) begin
      w_out_valid_next = 1'b1;
      w_out_data_next  = w_sel_data;
      w_out_src_next   = w_grant;
      w_out_last_next  = w_sel_last;
    end else if (out_ready) begin
      w_out_valid_next = 1'b0;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_lock_id_next = r_lock_id;
    case (r_state)
      ARB: begin
        if (w_accept) begin
          w_ptr_next = w_grant;
          if (!w_sel_last) begin
            w_state_next   = LOCK;
            w_lock_id_next = w_grant;
          end
        end
      end
      LOCK: begin
        if (w_accept && w_sel_last) begin
          w_state_next = ARB;
        end
      end
      default: begin
        w_state_next = ARB;
      end
    endcase
  end

  // ptr starts at N-1 so requester 0 is searched first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB;
      r_ptr       <= IW'(N - 1);
      r_lock_id   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_lock_id   <= w_lock_id_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_src   <= w_out_src_next;
      r_out_last  <= w_out_last_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: directed vectors with literal expectations, plus a
// last-winner/burst-owner model compared against the DUT on every cycle.
module tb_rr_mux_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_last;
  logic [W-1:0] req_data [0:N-1];
  logic [N-1:0] req_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_last;
  logic         out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int vnum     = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(
    .WIDTH (W),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: the owner of an open burst wins outright; otherwise the first
  // valid requester after the previous winner, wrapping around.
  int       m_known = 0;
  int       m_owner = -1;
  int       m_prev  = N - 1;
  bit       m_ov    = 1'b0;
  int       m_data  = 0;
  int       m_src   = 0;
  bit       m_lastf = 1'b0;

  always @(negedge clk) begin
    int           cand;
    bit           has;
    logic [N-1:0] exp_rdy;
    cand = 0;
    has  = 1'b0;
    if (m_owner >= 0) begin
      cand = m_owner;
      has  = req_valid[cand];
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!has && req_valid[(m_prev + k) % N]) begin
          cand = (m_prev + k) % N;
          has  = 1'b1;
        end
      end
    end
    exp_rdy = '0;
    if (!rst && m_known != 0 && has && (!m_ov || out_ready)) exp_rdy[cand] = 1'b1;

    if (rst || m_known != 0) chk("model_req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_known != 0) begin
      chk("model_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("model_out_data", 32'(out_data), 32'(m_data));
        chk("model_out_src",  32'(out_src),  32'(m_src));
        chk("model_out_last", 32'(out_last), 32'(m_lastf));
      end
    end

    if (rst) begin
      m_known = 1;
      m_owner = -1;
      m_prev  = N - 1;
      m_ov    = 1'b0;
      m_data  = 0;
      m_src   = 0;
      m_lastf = 1'b0;
    end else if (m_known != 0) begin
      if (exp_rdy != '0) begin
        m_ov    = 1'b1;
        m_data  = int'(req_data[cand]);
        m_src   = cand;
        m_lastf = req_last[cand];
        m_prev  = cand;
        m_owner = req_last[cand] ? -1 : cand;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // One directed cycle: drive, check at the falling edge, step past the rising edge.
  // co: 0 = ready only, 1 = also out_valid, 2 = also data/src/last.
  task automatic vec(input bit r, input logic [3:0] v, input logic [3:0] l,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3,
                     input bit ordy, input logic [3:0] er, input int co,
                     input bit eov, input logic [7:0] ed, input logic [1:0] es,
                     input bit el);
    rst         = r;
    req_valid   = v;
    req_last    = l;
    req_data[0] = d0;
    req_data[1] = d1;
    req_data[2] = d2;
    req_data[3] = d3;
    out_ready   = ordy;
    @(negedge clk);
    chk($sformatf("v%0d_req_ready", vnum), 32'(req_ready), 32'(er));
    if (co >= 1) chk($sformatf("v%0d_out_valid", vnum), 32'(out_valid), 32'(eov));
    if (co >= 2) begin
      chk($sformatf("v%0d_out_data", vnum), 32'(out_data), 32'(ed));
      chk($sformatf("v%0d_out_src",  vnum), 32'(out_src),  32'(es));
      chk($sformatf("v%0d_out_last", vnum), 32'(out_last), 32'(el));
    end
    $display("vec %0d: rst=%0b valid=%b last=%b ordy=%0b -> ready=%b ov=%0b data=%h src=%0d last=%0b",
             vnum, r, v, l, ordy, req_ready, out_valid, out_data, out_src, out_last);
    vnum++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_data[i] = '0;
    @(posedge clk);
    #1;

    // Reset state
    vec(1, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
    vec(1, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0000, 2, 0, 8'h00, 0, 0);
    // All four valid, single beats: sources 0,1,2,3,0 back to back
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0001, 2, 0, 8'h00, 0, 0);
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0010, 2, 1, 8'hA0, 0, 1);
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0100, 2, 1, 8'hA1, 1, 1);
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b1000, 2, 1, 8'hA2, 2, 1);
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0001, 2, 1, 8'hA3, 3, 1);
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0010, 2, 1, 8'hA0, 0, 1);
    vec(0, 4'h0, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0000, 2, 1, 8'hA1, 1, 1);
    vec(0, 4'h0, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0000, 2, 0, 8'hA1, 1, 1);
    // Re-reset, then a 3-beat burst from 1 while 2 waits
    vec(1, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
    vec(1, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 0, 8'h00, 0, 0);
    vec(0, 4'b0110, 4'b0100, 8'h00, 8'h11, 8'h22, 8'h00, 1, 4'b0010, 2, 0, 8'h00, 0, 0);
    vec(0, 4'b0110, 4'b0100, 8'h00, 8'h12, 8'h22, 8'h00, 1, 4'b0010, 2, 1, 8'h11, 1, 0);
    vec(0, 4'b0110, 4'b0110, 8'h00, 8'h13, 8'h22, 8'h00, 1, 4'b0010, 2, 1, 8'h12, 1, 0);
    vec(0, 4'b0100, 4'b0100, 8'h00, 8'h13, 8'h22, 8'h00, 1, 4'b0100, 2, 1, 8'h13, 1, 1);
    vec(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h22, 8'h00, 1, 4'b0000, 2, 1, 8'h22, 2, 1);
    // Backpressure: 8'h55 held for 5 stalled cycles, next word loads on release
    vec(0, 4'b0001, 4'b0001, 8'h55, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 2, 0, 8'h22, 2, 1);
    for (int i = 0; i < 5; i++)
      vec(0, 4'b0001, 4'b0001, 8'h66, 8'h00, 8'h00, 8'h00, 0, 4'b0000, 2, 1, 8'h55, 0, 1);
    vec(0, 4'b0001, 4'b0001, 8'h66, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 2, 1, 8'h55, 0, 1);
    vec(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 1, 8'h66, 0, 1);
    vec(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 0, 8'h66, 0, 1);
    // Wrap 3 -> 0, then all valid shows the pointer sits at 0 (requester 1 next)
    vec(0, 4'b1000, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h33, 1, 4'b1000, 2, 0, 8'h66, 0, 1);
    vec(0, 4'b0001, 4'b0001, 8'h44, 8'h00, 8'h00, 8'h33, 1, 4'b0001, 2, 1, 8'h33, 3, 1);
    vec(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 1, 8'h44, 0, 1);
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0010, 2, 0, 8'h44, 0, 1);
    vec(0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 1, 8'hA1, 1, 1);
    vec(0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 0, 8'hA1, 1, 1);
    // Reset in the middle of a 4-beat burst from requester 2
    vec(0, 4'b0100, 4'b0000, 8'h00, 8'h00, 8'hE1, 8'h00, 1, 4'b0100, 2, 0, 8'hA1, 1, 1);
    vec(0, 4'hF, 4'b0000, 8'hA0, 8'hA1, 8'hE2, 8'hA3, 1, 4'b0100, 2, 1, 8'hE1, 2, 0);
    vec(1, 4'hF, 4'b0000, 8'hA0, 8'hA1, 8'hE3, 8'hA3, 1, 4'b0000, 2, 1, 8'hE2, 2, 0);
    vec(0, 4'hF, 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 4'b0001, 2, 0, 8'h00, 0, 0);
    vec(0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 1, 8'hA0, 0, 1);
    vec(0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 2, 0, 8'hA0, 0, 1);

    // Random traffic, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 6);
        req_last[i]  = ($urandom_range(0, 9) < 4);
        req_data[i]  = W'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
